// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce, key-code
// decode and a small first-word-fall-through FIFO read by the CPU.
// Optional build macro KEYPAD_REPEAT_EN enables auto-repeat while a key
// stays held; without it, each debounced press yields exactly one code.
module keypad_scan_ctrl #(
   parameter int TICK_CYCLES    = 1_048_576,
   parameter int DEBOUNCE_TICKS = 2,
`ifdef KEYPAD_REPEAT_EN
   parameter int REPEAT_TICKS   = 25,
`endif
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   input  logic       rd_en,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       fifo_full,
   output logic       overflow,
   input  logic       clr_ovf,
   output logic       key_down
);

   localparam int TCNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 2);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;

   typedef enum logic [2:0] {IDLE, SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   logic [3:0]        row_s1, rs;
   logic [TCNT_W-1:0] tick_cnt;
   logic              tick;

   state_t            state, state_nxt;
   logic [1:0]        c, c_nxt;
   logic [3:0]        lrow, lrow_nxt;
   logic [DB_W-1:0]   db_cnt, db_nxt;
   logic [3:0]        col_nxt;
   logic              ghost;
   logic              push_entry, push;
   logic [1:0]        row_idx;
   logic [3:0]        code;

   logic [3:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [FCNT_W-1:0] count;
   logic              pop, wr_ok, drop;

   // Two-flop synchronizer for the asynchronous row pins.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1 <= 4'hF;
         rs     <= 4'hF;
      end else begin
         row_s1 <= row;
         rs     <= row_s1;
      end
   end

   // Free-running scan tick divider.
   always_ff @(posedge clk) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + TCNT_W'(1);
   end

   assign tick  = (tick_cnt == TCNT_W'(TICK_CYCLES - 1));
   assign ghost = ($countones(~lrow) > 1);

   // FSM state register plus registered column drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         c      <= 2'd0;
         lrow   <= 4'hF;
         db_cnt <= '0;
         col    <= 4'b0000;
      end else begin
         state  <= state_nxt;
         c      <= c_nxt;
         lrow   <= lrow_nxt;
         db_cnt <= db_nxt;
         col    <= col_nxt;
      end
   end

   // Next-state logic; transitions are only evaluated on tick cycles.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_nxt  = state;
      c_nxt      = c;
      lrow_nxt   = lrow;
      db_nxt     = db_cnt;
      push_entry = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (rs != 4'hF) begin
                  state_nxt = SCAN;
                  c_nxt     = 2'd0;
               end
            end
            SCAN: begin
               if (rs != 4'hF) begin
                  lrow_nxt  = rs;
                  db_nxt    = DB_W'(1);
                  state_nxt = DEBOUNCE;
               end else if (c != 2'd3) begin
                  c_nxt = c + 2'd1;
               end else begin
                  state_nxt = IDLE;
               end
            end
            DEBOUNCE: begin
               if (rs == lrow) begin
                  db_nxt = db_cnt + DB_W'(1);
                  if (db_nxt >= DB_W'(DEBOUNCE_TICKS)) begin
                     state_nxt  = PRESSED;
                     push_entry = !ghost;
                  end
               end else begin
                  state_nxt = IDLE;
               end
            end
            PRESSED: begin
               if (rs == 4'hF) begin
                  db_nxt    = DB_W'(1);
                  state_nxt = RELEASE;
               end
            end
            RELEASE: begin
               if (rs == 4'hF) begin
                  db_nxt = db_cnt + DB_W'(1);
                  if (db_nxt >= DB_W'(DEBOUNCE_TICKS)) state_nxt = IDLE;
               end else begin
                  state_nxt = PRESSED;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      col_nxt = (state_nxt == IDLE) ? 4'b0000 : ~(4'b0001 << c_nxt);
   end

   // Row index is the position of the single low bit in the latched row.
   always_comb begin
      row_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!lrow[i]) row_idx = 2'(i);
      end
   end

   assign code     = {row_idx, c};
   assign key_down = (state == PRESSED) && !ghost;

`ifdef KEYPAD_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
   logic [RPT_W-1:0] rpt_cnt;
   logic             stay_pressed, push_rpt;

   assign stay_pressed = (state == PRESSED) && (state_nxt == PRESSED);
   assign push_rpt     = tick && stay_pressed && !ghost &&
                         (rpt_cnt == RPT_W'(REPEAT_TICKS - 1));
   assign push         = push_entry | push_rpt;

   // Auto-repeat interval counter, cleared whenever PRESSED is left.
   always_ff @(posedge clk) begin
      if (rst || !stay_pressed) rpt_cnt <= '0;
      else if (push_rpt)        rpt_cnt <= '0;
      else if (tick)            rpt_cnt <= rpt_cnt + RPT_W'(1);
   end
`else
   assign push = push_entry;
`endif

   assign pop   = rd_en && key_valid;
   assign wr_ok = push && (!fifo_full || pop);
   assign drop  = push && fifo_full && !pop;

   // Key-code FIFO storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: storage is cleared on reset so the fall-through head reads 0 before the first push.
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'h0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= code;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_ok, pop})
            2'b10:   count <= count + FCNT_W'(1);
            2'b01:   count <= count - FCNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag; a drop wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)          overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

   assign key_code  = mem[rd_ptr];
   assign key_valid = (count != '0);
   assign fifo_full = (count == FCNT_W'(FIFO_DEPTH));

endmodule
